// File: rtl/demux_reg.sv
// demux_reg: registered 1-to-NUM demultiplexer.
// A word tagged with a lane select is accepted through a valid/ready
// handshake into one of NUM holding registers. Each lane is drained
// independently by its consumer through a per-lane valid/ack pair.
// Selects outside 0..NUM-1 are accepted and dropped, and a saturating
// counter records how many words were dropped this way.
module demux_reg #(
  parameter int NUM    = 16,
  parameter int SIGWID = 4,
  parameter int WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SIGWID-1:0]      s,
  input  logic [WIDTH-1:0]       d,
  output logic [NUM*WIDTH-1:0]   y,
  output logic [NUM-1:0]         out_valid,
  input  logic [NUM-1:0]         out_ack,
  output logic [4:0]             occupancy,
  output logic [7:0]             err_cnt
);

  logic [NUM*WIDTH-1:0] y_q, y_d;
  logic [NUM-1:0]       valid_q, valid_d;
  logic [4:0]           occ_q, occ_d;
  logic [7:0]           err_q, err_d;

  logic [NUM-1:0]       sel_hit;
  logic                 sel_oob;
  logic                 sel_full;
  logic                 xfer;

  // Population count of the next-state valid vector.
  function automatic logic [4:0] popcount(input logic [NUM-1:0] v);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM; i++) begin
      cnt = cnt + 5'(v[i]);
    end
    return cnt;
  endfunction

  // Saturating increment for the dropped-word counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Decode the select, derive the handshake and compute every next state.
  always_comb begin
    sel_hit = '0;
    for (int i = 0; i < NUM; i++) begin
      if (32'(s) == i) sel_hit[i] = 1'b1;
    end
    sel_oob  = (32'(s) >= NUM);
    // A lane being acknowledged this cycle frees up in the same edge,
    // which gives zero-bubble handoff on a full lane.
    sel_full = |(sel_hit & valid_q & ~out_ack);
    in_ready = ~sel_full;
    xfer     = in_valid & in_ready;

    valid_d = valid_q & ~out_ack;
    y_d     = y_q;
    if (xfer) begin
      valid_d = valid_d | sel_hit;
      for (int i = 0; i < NUM; i++) begin
        if (sel_hit[i]) y_d[i*WIDTH +: WIDTH] = d;
      end
    end
    occ_d = popcount(valid_d);

    err_d = err_q;
    if (xfer && sel_oob) err_d = sat_inc(err_q);
  end

  // State registers; reset clears data lanes as well as control.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      valid_q <= '0;
      occ_q   <= '0;
      err_q   <= '0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
      occ_q   <= occ_d;
      err_q   <= err_d;
    end
  end

  assign y         = y_q;
  assign out_valid = valid_q;
  assign occupancy = occ_q;
  assign err_cnt   = err_q;

endmodule
